// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with a 2-entry
// MDU write queue, with a starvation counter that stalls WB to drain the queue.
module regwrite_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned QDEPTH       = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        WbRegWrite,
    input  logic [4:0]  WbWriteReg,
    input  logic [31:0] WbWriteData,
    input  logic        MduValid,
    input  logic [4:0]  MduWriteReg,
    input  logic [31:0] MduWriteData,
    output logic        MduReady,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic        PendHit1,
    output logic        PendHit2,
    output logic        Stall,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData
);

    localparam int unsigned REG_W    = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned STARVE_W = 4;

    typedef struct packed {
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Queue storage: q_head is the oldest entry, q_tail the second
    wr_entry_t           q_head;
    wr_entry_t           q_tail;
    logic [CNT_W-1:0]    q_count;
    logic [STARVE_W-1:0] starve_cnt;

    wr_entry_t           q_head_next;
    wr_entry_t           q_tail_next;
    logic [CNT_W-1:0]    q_count_next;
    logic [STARVE_W-1:0] starve_cnt_next;

    logic wb_valid;
    logic q_nonempty;
    logic grant_q;
    logic grant_wb;
    logic push;
    wr_entry_t mdu_entry;

    assign wb_valid   = WbRegWrite && (WbWriteReg != REG_W'(0));
    assign q_nonempty = (q_count != CNT_W'(0));
    assign Stall      = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign MduReady   = !Reset && (32'(q_count) < QDEPTH);

    // Stall forces the head through; otherwise WB wins over a waiting entry
    assign grant_q  = q_nonempty && (Stall || !wb_valid);
    assign grant_wb = !Stall && wb_valid;

    // Writes to $0 complete the handshake but never occupy a slot
    assign push      = MduValid && MduReady && (MduWriteReg != REG_W'(0));
    assign mdu_entry = '{reg_addr: MduWriteReg, data: MduWriteData};

    // Queue next state: pop shifts tail to head, push lands in first free slot
    always_comb begin
        q_head_next  = q_head;
        q_tail_next  = q_tail;
        q_count_next = q_count;
        if (grant_q) begin
            q_head_next  = q_tail;
            q_count_next = q_count - CNT_W'(1);
        end
        if (push) begin
            if (q_count_next == CNT_W'(0)) begin
                q_head_next = mdu_entry;
            end else begin
                q_tail_next = mdu_entry;
            end
            q_count_next = q_count_next + CNT_W'(1);
        end
    end

    // Starvation counter: counts lost cycles of the current head, saturating
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!q_nonempty || grant_q) begin
            starve_cnt_next = '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_head     <= '0;
            q_tail     <= '0;
            q_count    <= '0;
            starve_cnt <= '0;
        end else begin
            q_head     <= q_head_next;
            q_tail     <= q_tail_next;
            q_count    <= q_count_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Registered write port; reg/data hold their last value when idle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (grant_q) begin
            RegWrite  <= 1'b1;
            WriteReg  <= q_head.reg_addr;
            WriteData <= q_head.data;
        end else if (grant_wb) begin
            RegWrite  <= 1'b1;
            WriteReg  <= WbWriteReg;
            WriteData <= WbWriteData;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Pending-write lookup over live queue slots and the port in flight
    always_comb begin
        PendHit1 = 1'b0;
        PendHit2 = 1'b0;
        if (!Reset) begin
            PendHit1 = (ReadReg1 != REG_W'(0)) &&
                       ((q_nonempty && (q_head.reg_addr == ReadReg1)) ||
                        ((q_count == CNT_W'(2)) && (q_tail.reg_addr == ReadReg1)) ||
                        (RegWrite && (WriteReg == ReadReg1)));
            PendHit2 = (ReadReg2 != REG_W'(0)) &&
                       ((q_nonempty && (q_head.reg_addr == ReadReg2)) ||
                        ((q_count == CNT_W'(2)) && (q_tail.reg_addr == ReadReg2)) ||
                        (RegWrite && (WriteReg == ReadReg2)));
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: port writes are checked in order
// against a queue of expected (reg, data) pairs, plus timing/flag checks.
module tb_regwrite_arbiter;

    logic        Clk;
    logic        Reset;
    logic        WbRegWrite;
    logic [4:0]  WbWriteReg;
    logic [31:0] WbWriteData;
    logic        MduValid;
    logic [4:0]  MduWriteReg;
    logic [31:0] MduWriteData;
    logic        MduReady;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic        PendHit1;
    logic        PendHit2;
    logic        Stall;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;

    regwrite_arbiter #(.STARVE_LIMIT(4), .QDEPTH(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .WbRegWrite(WbRegWrite), .WbWriteReg(WbWriteReg), .WbWriteData(WbWriteData),
        .MduValid(MduValid), .MduWriteReg(MduWriteReg), .MduWriteData(MduWriteData),
        .MduReady(MduReady),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .PendHit1(PendHit1), .PendHit2(PendHit2),
        .Stall(Stall),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then retire any port write against the scoreboard
    task automatic step();
        wr_t e;
        @(posedge Clk);
        #1;
        if (RegWrite === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(WriteReg), 32'h0000_00FF);
            end else begin
                e = sb.pop_front();
                chk("sb_reg", 32'(WriteReg), 32'(e.r));
                chk("sb_data", WriteData, e.d);
            end
        end
    endtask

    task automatic wb(input logic v, input logic [4:0] r, input logic [31:0] d);
        WbRegWrite = v; WbWriteReg = r; WbWriteData = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
        MduValid = v; MduWriteReg = r; MduWriteData = d;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.r = r; e.d = d;
        sb.push_back(e);
    endtask

    initial begin
        Reset = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd0;

        // Reset state
        step(); step();
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_writereg", 32'(WriteReg), 32'd0);
        chk("rst_writedata", WriteData, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_mduready", 32'(MduReady), 32'd0);
        chk("rst_pendhit1", 32'(PendHit1), 32'd0);
        Reset = 1'b0;
        step();
        chk("rel_mduready", 32'(MduReady), 32'd1);

        // WB only: one-cycle latency, then idle with reg/data held
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        step();
        chk("wb_regwrite", 32'(RegWrite), 32'd1);
        wb(1'b0, 5'd0, 32'd0);
        step();
        chk("wb_idle", 32'(RegWrite), 32'd0);
        chk("wb_hold_reg", 32'(WriteReg), 32'd5);
        chk("wb_hold_data", WriteData, 32'hDEAD_BEEF);

        // MDU idle path: two-cycle latency, no bypass
        chk("mdu_ready0", 32'(MduReady), 32'd1);
        mdu(1'b1, 5'd9, 32'h1234_5678);
        expect_wr(5'd9, 32'h1234_5678);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        chk("mdu_nobypass", 32'(RegWrite), 32'd0);
        chk("mdu_ready1", 32'(MduReady), 32'd1);
        ReadReg1 = 5'd9;
        #1;
        chk("mdu_pend_q", 32'(PendHit1), 32'd1);
        step();
        chk("mdu_write", 32'(RegWrite), 32'd1);
        step();
        chk("mdu_idle", 32'(RegWrite), 32'd0);

        // Hazard lookup and $0 discard
        mdu(1'b1, 5'd7, 32'h0000_0777);
        step();
        mdu(1'b1, 5'd0, 32'hBAD0_0000);
        wb(1'b1, 5'd20, 32'h0000_00A0);
        expect_wr(5'd20, 32'h0000_00A0);
        expect_wr(5'd7, 32'h0000_0777);
        ReadReg1 = 5'd7;
        ReadReg2 = 5'd0;
        #1;
        chk("haz_pend1", 32'(PendHit1), 32'd1);
        chk("haz_pend2_r0", 32'(PendHit2), 32'd0);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        chk("r0_no_growth", 32'(MduReady), 32'd1);
        ReadReg2 = 5'd20;
        #1;
        chk("haz_pend_port", 32'(PendHit2), 32'd1);
        step();
        step();
        chk("haz_idle", 32'(RegWrite), 32'd0);
        #1;
        chk("haz_pend_clear", 32'(PendHit1), 32'd0);

        // Starvation: 4 lost cycles raise Stall, head drains, held WB follows
        wb(1'b1, 5'd1, 32'h0000_0101);
        mdu(1'b1, 5'd11, 32'h0000_0B11);
        expect_wr(5'd1, 32'h0000_0101);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        for (int i = 2; i <= 5; i++) begin
            wb(1'b1, 5'(i), 32'h100 + 32'(i));
            expect_wr(5'(i), 32'h100 + 32'(i));
            step();
            chk("starve_stall", 32'(Stall), (i == 5) ? 32'd1 : 32'd0);
        end
        wb(1'b1, 5'd6, 32'h0000_0106);
        expect_wr(5'd11, 32'h0000_0B11);
        expect_wr(5'd6, 32'h0000_0106);
        step();
        chk("stall_drain_reg", 32'(WriteReg), 32'd11);
        chk("stall_release", 32'(Stall), 32'd0);
        step();
        chk("held_wb_reg", 32'(WriteReg), 32'd6);
        wb(1'b0, 5'd0, 32'd0);
        step();

        // Queue full: third MDU request is held off until a slot frees
        wb(1'b1, 5'd1, 32'h0000_0201);
        mdu(1'b1, 5'd12, 32'h0000_0C12);
        expect_wr(5'd1, 32'h0000_0201);
        step();
        wb(1'b1, 5'd2, 32'h0000_0202);
        mdu(1'b1, 5'd13, 32'h0000_0C13);
        expect_wr(5'd2, 32'h0000_0202);
        step();
        chk("full_ready", 32'(MduReady), 32'd0);
        wb(1'b1, 5'd3, 32'h0000_0203);
        mdu(1'b1, 5'd14, 32'h0000_0C14);
        expect_wr(5'd3, 32'h0000_0203);
        expect_wr(5'd12, 32'h0000_0C12);
        expect_wr(5'd13, 32'h0000_0C13);
        expect_wr(5'd14, 32'h0000_0C14);
        step();
        chk("full_hold", 32'(MduReady), 32'd0);
        wb(1'b0, 5'd0, 32'd0);
        step();
        chk("full_slot_free", 32'(MduReady), 32'd1);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        chk("pushpop_count", 32'(MduReady), 32'd1);
        step();
        chk("full_last_reg", 32'(WriteReg), 32'd14);
        step();
        chk("full_idle", 32'(RegWrite), 32'd0);

        // Reset mid-queue: queued entries and the in-flight write vanish
        wb(1'b1, 5'd1, 32'h0000_0301);
        mdu(1'b1, 5'd21, 32'h0000_0D21);
        expect_wr(5'd1, 32'h0000_0301);
        step();
        wb(1'b1, 5'd2, 32'h0000_0302);
        mdu(1'b1, 5'd22, 32'h0000_0D22);
        expect_wr(5'd2, 32'h0000_0302);
        step();
        chk("rq_full", 32'(MduReady), 32'd0);
        Reset = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        ReadReg1 = 5'd21;
        #1;
        chk("rq_rst_ready", 32'(MduReady), 32'd0);
        chk("rq_rst_pend", 32'(PendHit1), 32'd0);
        step();
        chk("rq_regwrite", 32'(RegWrite), 32'd0);
        chk("rq_writereg", 32'(WriteReg), 32'd0);
        chk("rq_stall", 32'(Stall), 32'd0);
        Reset = 1'b0;
        step();
        chk("rq_ready_rel", 32'(MduReady), 32'd1);
        chk("rq_pend_gone", 32'(PendHit1), 32'd0);
        repeat (4) step();
        chk("rq_no_issue", 32'(RegWrite), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
